deser8_rx: RTL

DESER8_RX -- requirements
Module: deser8_rx

---
 rtl/deser8_rx.sv | 122 ++++++++++++
 1 files changed

// File: rtl/deser8_rx.sv
// rtl/deser8_rx.sv - strobed 8-bit MSB-first serial receiver with stop-bit framing check
// Optional even-parity bit, state PAR and port perr are enabled by defining PARITY_EN.

module deser8_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       sin,
  input  logic       en,
  output logic [7:0] q,
  output logic       valid,
  output logic       busy,
  output logic       ferr
`ifdef PARITY_EN
  ,
  output logic       perr
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
`ifdef PARITY_EN
    PAR  = 2'd2,
`endif
    STOP = 2'd3
  } state_t;

  state_t     state, state_n;
  logic [7:0] sr, sr_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] q_n;
  logic       valid_n;
  logic       ferr_n;
`ifdef PARITY_EN
  logic       par_bad, par_bad_n;
  logic       perr_n;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sr      <= 8'h00;
      cnt     <= 3'd0;
      q       <= 8'h00;
      valid   <= 1'b0;
      ferr    <= 1'b0;
`ifdef PARITY_EN
      par_bad <= 1'b0;
      perr    <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      cnt     <= cnt_n;
      q       <= q_n;
      valid   <= valid_n;
      ferr    <= ferr_n;
`ifdef PARITY_EN
      par_bad <= par_bad_n;
      perr    <= perr_n;
`endif
    end
  end

  // Everything holds unless en strobes; pulses default low every cycle.
  always_comb begin
    state_n   = state;
    sr_n      = sr;
    cnt_n     = cnt;
    q_n       = q;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
`ifdef PARITY_EN
    par_bad_n = par_bad;
    perr_n    = 1'b0;
`endif
    if (en) begin
      case (state)
        IDLE: begin
          if (!sin) begin
            state_n = DATA;
            cnt_n   = 3'd0;
          end
        end
        DATA: begin
          sr_n  = {sr[6:0], sin};
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) begin
`ifdef PARITY_EN
            state_n = PAR;
`else
            state_n = STOP;
`endif
          end
        end
`ifdef PARITY_EN
        PAR: begin
          // Even parity: data bits plus parity bit must XOR to zero.
          par_bad_n = (^sr) ^ sin;
          state_n   = STOP;
        end
`endif
        STOP: begin
          if (sin) begin
            q_n     = sr;
            valid_n = 1'b1;
          end else begin
            ferr_n  = 1'b1;
          end
`ifdef PARITY_EN
          perr_n    = par_bad;
`endif
          state_n   = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
